fpaddsub_normalize_shift0: RTL

- Normalization front stage of the FP adder/subtractor. Takes the raw 33-bit mantissa sum and its exponent, and computes the leading-zero count. It then applies the coarse 0|16-bit left shift and adjusts the exponent.
- Hands the partially shifted mantissa plus the residual 5-bit shift amount to the downstream fine-shift stage. That stage performs the remaining 12|8|4|3|2|1|0 shift.
- Two-stage valid/ready pipeline, so the adder can stall without losing data.

---
 rtl/fpaddsub_normalize_shift0.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fpaddsub_normalize_shift0.sv
// rtl/fpaddsub_normalize_shift0.sv - FP add/sub normalization front stage: LZC, coarse 16-bit shift, exponent adjust
module fpaddsub_normalize_shift0 #(
    parameter int MW = 33,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] Sum,
    input  logic [EW-1:0] ExpIn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] MminP,
    output logic [4:0]    Shift,
    output logic [EW-1:0] ExpOut,
    output logic          ZeroSum,
    output logic          Underflow
);

    logic          rst_done_q, rst_done_d;
    logic          s1_valid_q, s1_valid_d;
    logic [MW-1:0] s1_sum_q,   s1_sum_d;
    logic [EW-1:0] s1_exp_q,   s1_exp_d;
    logic [5:0]    s1_lzc_q,   s1_lzc_d;
    logic          s2_valid_q, s2_valid_d;
    logic [MW-1:0] mminp_q,    mminp_d;
    logic [4:0]    shift_q,    shift_d;
    logic [EW-1:0] exp_out_q,  exp_out_d;
    logic          zero_q,     zero_d;
    logic          uf_q,       uf_d;

    logic          s2_ready;
    logic [5:0]    lzc;
    logic [4:0]    sh;
    logic          sum_zero;
    logic          uf;

    // Ascending scan: the highest set bit is the last one to write lzc.
    always_comb begin
        lzc = 6'd33;
        for (int i = 0; i < MW; i++) begin
            if (Sum[i]) lzc = 6'(MW - 1 - i);
        end
    end

    always_comb begin
        s2_ready = ~s2_valid_q | out_ready;
        in_ready = rst_done_q & (~s1_valid_q | s2_ready);

        sh       = (s1_lzc_q > 6'd31) ? 5'd31 : s1_lzc_q[4:0];
        sum_zero = (s1_sum_q == '0);
        uf       = (EW + 1)'(sh) > (EW + 1)'(s1_exp_q);

        rst_done_d = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_exp_d   = s1_exp_q;
        s1_lzc_d   = s1_lzc_q;
        s2_valid_d = s2_valid_q;
        mminp_d    = mminp_q;
        shift_d    = shift_q;
        exp_out_d  = exp_out_q;
        zero_d     = zero_q;
        uf_d       = uf_q;

        if (in_ready) s1_valid_d = in_valid;
        if (in_ready && in_valid) begin
            s1_sum_d = Sum;
            s1_exp_d = ExpIn;
            s1_lzc_d = lzc;
        end

        if (s2_ready) s2_valid_d = s1_valid_q;
        if (s2_ready && s1_valid_q) begin
            if (sum_zero) begin
                mminp_d   = '0;
                shift_d   = 5'd0;
                exp_out_d = '0;
                zero_d    = 1'b1;
                uf_d      = 1'b0;
            end else begin
                mminp_d   = sh[4] ? {s1_sum_q[MW-17:0], 16'b0} : s1_sum_q;
                shift_d   = sh;
                exp_out_d = uf ? '0 : s1_exp_q - EW'(sh);
                zero_d    = 1'b0;
                uf_d      = uf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
            s2_valid_q <= 1'b0;
            mminp_q    <= '0;
            shift_q    <= '0;
            exp_out_q  <= '0;
            zero_q     <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            rst_done_q <= rst_done_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_exp_q   <= s1_exp_d;
            s1_lzc_q   <= s1_lzc_d;
            s2_valid_q <= s2_valid_d;
            mminp_q    <= mminp_d;
            shift_q    <= shift_d;
            exp_out_q  <= exp_out_d;
            zero_q     <= zero_d;
            uf_q       <= uf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign MminP     = mminp_q;
    assign Shift     = shift_q;
    assign ExpOut    = exp_out_q;
    assign ZeroSum   = zero_q;
    assign Underflow = uf_q;

endmodule
